// File: rtl/int_mul_pkg.sv
// rtl/int_mul_pkg.sv - shared types and constants for the sequential integer multiplier
//
// Contents:
//   mul_op_e      : multiply variant, encoded as funct3[1:0]
//   mul_state_e   : control FSM states
//   MUL_XLEN_DEF  : default operand width
//   MUL_CNT_W     : step-counter width for the default width, $clog2(XLEN+1)
//
// Optional feature macro: MUL_EARLY_EXIT_EN (used by int_mul_seq / int_mul_fix)

package int_mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'd0,
        MUL_OP_MULH   = 2'd1,
        MUL_OP_MULHSU = 2'd2,
        MUL_OP_MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    localparam int MUL_XLEN_DEF = 32;
    localparam int MUL_CNT_W    = $clog2(MUL_XLEN_DEF + 1);

endpackage

// File: rtl/int_mul_fix.sv
// rtl/int_mul_fix.sv - product sign fix-up and half select for the sequential multiplier
//
// Purely combinational.
// Ports:
//   i_prod   [2*XLEN-1:0] unsigned magnitude product from the shift register
//   i_count  [CNT_W-1:0]  steps actually performed (MUL_EARLY_EXIT_EN only)
//   i_neg                 negate the product (operand signs differ)
//   i_op                  multiply variant; MUL selects the low half, all others the high half
//   o_result [XLEN-1:0]   selected half of the signed/unsigned product
//
// Optional feature macro: MUL_EARLY_EXIT_EN adds the right-alignment shifter.

module int_mul_fix
    import int_mul_pkg::*;
#(
    parameter int XLEN = MUL_XLEN_DEF
`ifdef MUL_EARLY_EXIT_EN
    ,
    parameter int CNT_W = $clog2(XLEN + 1)
`endif
) (
    input  logic [2*XLEN-1:0] i_prod,
`ifdef MUL_EARLY_EXIT_EN
    input  logic [CNT_W-1:0]  i_count,
`endif
    input  logic              i_neg,
    input  mul_op_e           i_op,
    output logic [XLEN-1:0]   o_result
);

    logic [2*XLEN-1:0] mag;
    logic [2*XLEN-1:0] prod_signed;

    always_comb begin
`ifdef MUL_EARLY_EXIT_EN
        // After an early exit the product still sits (XLEN - count) places too
        // far left; the skipped steps would only have shifted in zeros.
        mag = i_prod >> (CNT_W'(XLEN) - i_count);
`else
        mag = i_prod;
`endif
        // Two's-complement negate over the full 2*XLEN width; -0 stays 0.
        prod_signed = i_neg ? ('0 - mag) : mag;
        o_result    = (i_op == MUL_OP_MUL) ? prod_signed[XLEN-1:0]
                                           : prod_signed[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/int_mul_seq.sv
// rtl/int_mul_seq.sv - multi-cycle shift-add multiplier (MUL/MULH/MULHSU/MULHU)
//
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_valid, o_ready     request handshake; accepted when both high (o_ready only in IDLE)
//   i_op [1:0]           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_a, i_b [XLEN-1:0]  rs1 multiplicand, rs2 multiplier
//   o_valid, i_ready     result handshake; consumed when both high in DONE
//   o_result [XLEN-1:0]  selected product half, held until the next FIX
//
// Optional feature macro: MUL_EARLY_EXIT_EN - stop CALC once the remaining
// multiplier bits are zero; results are identical, only latency changes.

module int_mul_seq
    import int_mul_pkg::*;
#(
    parameter int XLEN = MUL_XLEN_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = (XLEN == MUL_XLEN_DEF) ? MUL_CNT_W : $clog2(XLEN + 1);

    mul_state_e      state;
    mul_op_e         op_q;
    logic            neg_q;
    logic [XLEN-1:0] a_mag;
    // Shift register {acc, mplr}: acc collects the high partial product,
    // mplr starts as |b| and fills with low product bits as it shifts right.
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mplr;
    logic [CNT_W-1:0] count;
`ifdef MUL_EARLY_EXIT_EN
    logic [XLEN-1:0] b_rem;
`endif

    mul_op_e         op_in;
    logic            a_neg_in;
    logic            b_neg_in;
    logic [XLEN-1:0] a_mag_in;
    logic [XLEN-1:0] b_mag_in;
    logic [XLEN:0]   sum;
    logic            last_step;
    logic [XLEN-1:0] fix_result;

    always_comb begin
        op_in    = mul_op_e'(i_op);
        a_neg_in = ((op_in == MUL_OP_MULH) || (op_in == MUL_OP_MULHSU)) && i_a[XLEN-1];
        b_neg_in = (op_in == MUL_OP_MULH) && i_b[XLEN-1];
        // Magnitude of -2^(XLEN-1) wraps to 2^(XLEN-1), which is correct unsigned.
        a_mag_in = a_neg_in ? ('0 - i_a) : i_a;
        b_mag_in = b_neg_in ? ('0 - i_b) : i_b;

        sum = mplr[0] ? ({1'b0, acc} + {1'b0, a_mag}) : {1'b0, acc};

        last_step = (count == CNT_W'(XLEN - 1));
`ifdef MUL_EARLY_EXIT_EN
        // Bit 0 is consumed this cycle; if nothing above it is set, stop.
        if (b_rem[XLEN-1:1] == '0) begin
            last_step = 1'b1;
        end
`endif
    end

    int_mul_fix #(
        .XLEN (XLEN)
`ifdef MUL_EARLY_EXIT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) u_fix (
        .i_prod  ({acc, mplr}),
`ifdef MUL_EARLY_EXIT_EN
        .i_count (count),
`endif
        .i_neg   (neg_q),
        .i_op    (op_q),
        .o_result(fix_result)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            op_q     <= MUL_OP_MUL;
            neg_q    <= 1'b0;
            a_mag    <= '0;
            acc      <= '0;
            mplr     <= '0;
            count    <= '0;
`ifdef MUL_EARLY_EXIT_EN
            b_rem    <= '0;
`endif
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
            o_result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        op_q    <= op_in;
                        neg_q   <= a_neg_in ^ b_neg_in;
                        a_mag   <= a_mag_in;
                        acc     <= '0;
                        mplr    <= b_mag_in;
                        count   <= '0;
`ifdef MUL_EARLY_EXIT_EN
                        b_rem   <= b_mag_in;
`endif
                        o_ready <= 1'b0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Add-then-shift: the carry out of the add lands in acc's MSB.
                    acc   <= sum[XLEN:1];
                    mplr  <= {sum[0], mplr[XLEN-1:1]};
                    count <= count + CNT_W'(1);
`ifdef MUL_EARLY_EXIT_EN
                    b_rem <= b_rem >> 1;
`endif
                    if (last_step) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    o_result <= fix_result;
                    o_valid  <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_mul_seq.sv
// tb/tb_int_mul_seq.sv - directed self-checking bench for int_mul_seq (XLEN=32)

module tb_int_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    int_mul_seq #(.XLEN(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .o_valid (valid_out),
        .i_ready (ready_in),
        .o_result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges from accept to o_valid.
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] bv);
`ifdef MUL_EARLY_EXIT_EN
        logic [31:0] m;
        int n;
        m = (o == 2'b01 && bv[31]) ? (32'd0 - bv) : bv;
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) n = i + 1;
        end
        return n + 1;
`else
        return 33;
`endif
    endfunction

    // Issue one request, wait for the result, check it, then consume it.
    task automatic run_mul(input string tag, input logic [1:0] o, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] exp, input bit early_ready);
        int lat;
        bit rdy_bad;
        @(negedge clk);
        chk({tag, "_ready_idle"}, 64'(ready_out), 64'd1);
        valid_in = 1'b1; op = o; a = av; b = bv; ready_in = early_ready;
        @(negedge clk);
        valid_in = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 0;
        rdy_bad = 1'b0;
        while (valid_out !== 1'b1 && lat < 200) begin
            if (ready_out !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(o, bv)));
        chk({tag, "_ready_busy"}, 64'(rdy_bad), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'(exp));
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        chk({tag, "_valid_drop"}, 64'(valid_out), 64'd0);
        chk({tag, "_ready_back"}, 64'(ready_out), 64'd1);
        chk({tag, "_result_hold"}, 64'(result), 64'(exp));
    endtask

    initial begin
        int lat;
        bit stable_bad;
        logic [31:0] held;

        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready_out), 64'd1);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        rst_n = 1'b1;

        run_mul("mul_7_m3",      2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_mul("mulh_7_m3",     2'b01, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_mul("mulh_min_min",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        run_mul("mul_min_min",   2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0);
        run_mulhu_ff:
        run_mul("mulhu_ff_ff",   2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_mul("mul_ff_ff",     2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_mul("mulhsu_ff_ff",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_mul("mulh_m1_m1",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_mul("mulh_neg_zero", 2'b01, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
        run_mul("mul_early_rdy", 2'b00, 32'h12345678, 32'd5,        32'h5B05B058, 1'b1);
        run_mul("mul_b_zero",    2'b00, 32'hDEADBEEF, 32'd0,        32'h00000000, 1'b0);

        // Backpressure: result held while i_ready is low.
        @(negedge clk);
        valid_in = 1'b1; op = 2'b11; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk);
        valid_in = 1'b0;
        lat = 0;
        while (valid_out !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'(exp_lat(2'b11, 32'hFFFFFFFF)));
        held = result;
        stable_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (result !== 32'hFFFFFFFE || valid_out !== 1'b1 || ready_out !== 1'b0) stable_bad = 1'b1;
        end
        chk("bp_stable", 64'(stable_bad), 64'd0);
        chk("bp_result", 64'(held), 64'hFFFFFFFE);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        chk("bp_valid_drop", 64'(valid_out), 64'd0);
        chk("bp_ready_back", 64'(ready_out), 64'd1);
        valid_in = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
        @(negedge clk);
        valid_in = 1'b0;
        chk("bp_next_accepted", 64'(ready_out), 64'd0);
        lat = 0;
        while (valid_out !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_next_result", 64'(result), 64'd6);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;

        // Reset in the middle of CALC discards the operation.
        valid_in = 1'b1; op = 2'b00; a = 32'd1000; b = 32'hFFFFFFFF;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_valid", 64'(valid_out), 64'd0);
        chk("abort_ready", 64'(ready_out), 64'd1);
        chk("abort_result", 64'(result), 64'd0);
        run_mul("mul_3_4_after_abort", 2'b00, 32'd3, 32'd4, 32'h0000000C, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_mul_seq.md
# int_mul_seq

Parametrised, multi-cycle shift-add integer multiplier for the ALU's M-extension path. Supports all four RISC-V multiply variants (MUL, MULH, MULHSU, MULHU) at configurable width XLEN. Uses a valid/ready handshake on both input and output so the issue stage can stall it. Successor to the fixed-width sign-magnitude multiplier: full two's-complement results, high-half selection and output backpressure.

## Interface

- XLEN, 32, operand/result width; ≥ 4.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset; one clock, synchronous, active-low.
- i_valid  in  1  request valid.
- o_ready  out  1  request accepted when i_valid && o_ready.
- i_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- i_a  in  XLEN  multiplicand (rs1).
- i_b  in  XLEN  multiplier (rs2).
- o_valid  out  1  result valid.
- i_ready  in  1  result consumed when o_valid && i_ready.
- o_result  out  XLEN  selected product half.

## Operation

- States: IDLE, CALC, FIX, DONE. Reset → IDLE, count=0, accumulator=0, o_valid=0, o_ready=1, o_result=0.
- o_ready = (state==IDLE). Inputs are sampled only on the accept edge; ignored otherwise.
- Accept (IDLE): latch op. a_signed = op∈{MULH,MULHSU}; b_signed = op==MULH. neg = (a_signed&a[XLEN-1]) ^ (b_signed&b[XLEN-1]). Latch |a|, |b| as XLEN-bit unsigned magnitudes; |−2^(XLEN-1)| = 2^(XLEN-1) fits. Shift register {acc[XLEN:0], mplr[XLEN-1:0]} = {0, |b|}. → CALC, count=0.
- CALC: each cycle, if mplr LSB set, acc += |a| (XLEN+1-bit). Then shift whole register right 1; count++. After count==XLEN-1 step → FIX.
- FIX: P = 2·XLEN-bit magnitude product; if neg, P = −P (two's complement, 2·XLEN bits; −0 = 0). o_result ← P[XLEN-1:0] for MUL, else P[2XLEN-1:XLEN]. o_valid ← 1. → DONE.
- DONE: hold o_result and o_valid until i_ready. On handshake edge → IDLE, o_valid ← 0, o_result holds its value.
- Reset at any state: synchronous abort → reset values next edge; the in-flight result is discarded.

## Timing

- Accept at edge E0. CALC occupies edges E1..E_XLEN. FIX at E_(XLEN+1). o_valid high from E_(XLEN+1), i.e. XLEN+1 cycles after accept (33 for XLEN=32).
- Minimum issue interval: XLEN+3 cycles (DONE→IDLE costs one cycle; no accept in DONE).
- i_ready high during FIX has no effect; handshake is only counted in DONE.
- o_result changes only at the FIX edge and at reset.

## Configuration

- MUL_EARLY_EXIT_EN defined: in CALC, if the mplr bits still to be consumed after the current step are all zero, go to FIX immediately; FIX right-aligns the accumulator by the remaining (XLEN−count) positions before sign fix. CALC length = max(1, msb_index(|b|)+1). |b|=0 → 1 cycle. Results are bit-identical to the fixed-latency mode.
- Undefined: fixed XLEN CALC cycles; no alignment shifter.

## Structure

- Package int_mul_pkg: op enum (MUL_OP_MUL/MULH/MULHSU/MULHU = 0..3), state enum, localparam for the count width $clog2(XLEN+1).
- Sub-module int_mul_fix: combinational 2·XLEN conditional negate + half select (+ alignment shift under MUL_EARLY_EXIT_EN). Instantiated once in FIX path.

## Test plan

- MUL 7 × 0xFFFFFFFD (−3), XLEN=32, macro off → o_result 0xFFFFFFEB; o_valid exactly 33 cycles after accept; o_ready low throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MUL same operands → 0x00000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MUL same operands → 0x00000001; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid → o_result and o_valid stable, o_ready=0; raise i_ready → next cycle o_valid=0, o_ready=1, new request accepted the following edge.
- Reset mid-CALC (count=10) → next cycle o_valid=0, o_ready=1, o_result=0; following request MUL 3×4 → 0x0000000C.
- Macro on: MUL 0x12345678 × 5 → 0x5B05B058 with o_valid 4 cycles after accept; b=0 → 0, o_valid 2 cycles after accept.
